// File: rtl/distance_pkg.sv
// Shared types and defaults for the distance countdown display block.
package distance_pkg;

   typedef struct packed {
      logic [3:0] hundreds;
      logic [3:0] tens;
      logic [3:0] units;
   } bcd3_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_e;

   localparam int unsigned FRAME_DIV_DEF = 80;
   localparam logic [11:0] START_BCD_DEF = 12'h200;
   localparam logic [11:0] WARN_BCD_DEF  = 12'h050;

   // Non-decimal nibbles saturate to 9 so the counter always holds legal BCD.
   function automatic bcd3_t clamp_bcd(input logic [11:0] raw);
      bcd3_t r;
      r = bcd3_t'(raw);
      if (r.hundreds > 4'd9) r.hundreds = 4'd9;
      if (r.tens > 4'd9)     r.tens     = 4'd9;
      if (r.units > 4'd9)    r.units    = 4'd9;
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrement with borrow chain; chained three times by distance_counter.
module bcd_digit_dec (
   input  logic [3:0] i_digit,
   input  logic       i_borrow,
   output logic [3:0] o_digit,
   output logic       o_borrow
);

   always_comb begin
      o_digit  = i_digit;
      o_borrow = 1'b0;
      if (i_borrow) begin
         if (i_digit == 4'd0) begin
            o_digit  = 4'd9;
            o_borrow = 1'b1;
         end else begin
            o_digit = i_digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/distance_counter.sv
// Frame-paced 3-digit BCD countdown with latest-value handshake to a renderer.
// Optional warning output enabled by macro DIST_WARN_EN.
module distance_counter
   import distance_pkg::*;
#(
   parameter int unsigned FRAME_DIV = FRAME_DIV_DEF,
   parameter logic [11:0] START_BCD = START_BCD_DEF
`ifdef DIST_WARN_EN
   ,parameter logic [11:0] WARN_BCD = WARN_BCD_DEF
`endif
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_v_sync,
   input  logic        i_start,
   input  logic        i_load,
   input  logic [11:0] i_load_bcd,
   input  logic        i_pause,
   input  logic        i_ready,
   output logic [3:0]  o_hundreds,
   output logic [3:0]  o_tens,
   output logic [3:0]  o_units,
   output logic        o_valid,
   output logic        o_busy,
   output logic        o_done
`ifdef DIST_WARN_EN
   ,output logic       o_warn
`endif
);

   localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

   logic   sync1_q, sync1_d;
   logic   sync2_q, sync2_d;
   logic   sync3_q, sync3_d;
   state_e state_q, state_d;
   bcd3_t  digits_q, digits_d;
   logic [7:0] frame_q, frame_d;
   logic   valid_q, valid_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;
`ifdef DIST_WARN_EN
   logic   warn_q, warn_d;
`endif

   logic   tick;
   logic   changed;
   bcd3_t  dec_val;
   logic   borrow_u, borrow_t, borrow_h;

   assign tick = sync2_q & ~sync3_q;

   bcd_digit_dec u_dec_units (
      .i_digit  (digits_q.units),
      .i_borrow (1'b1),
      .o_digit  (dec_val.units),
      .o_borrow (borrow_u)
   );

   bcd_digit_dec u_dec_tens (
      .i_digit  (digits_q.tens),
      .i_borrow (borrow_u),
      .o_digit  (dec_val.tens),
      .o_borrow (borrow_t)
   );

   bcd_digit_dec u_dec_hundreds (
      .i_digit  (digits_q.hundreds),
      .i_borrow (borrow_t),
      .o_digit  (dec_val.hundreds),
      .o_borrow (borrow_h)
   );

   always_comb begin
      sync1_d  = i_v_sync;
      sync2_d  = sync1_q;
      sync3_d  = sync2_q;
      state_d  = state_q;
      digits_d = digits_q;
      frame_d  = frame_q;
      changed  = 1'b0;

      if (i_start) begin
         digits_d = clamp_bcd(i_load ? i_load_bcd : START_BCD);
         frame_d  = '0;
         changed  = 1'b1;
         state_d  = (digits_d == '0) ? ST_DONE : ST_RUN;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (i_pause) begin
                  state_d = ST_PAUSE;
               end else if (tick) begin
                  if (frame_q == DIV_LAST) begin
                     frame_d = '0;
                     // A hundreds borrow would mean wrapping below 000; never let that through.
                     if (!borrow_h) begin
                        digits_d = dec_val;
                        changed  = 1'b1;
                        if (dec_val == '0) state_d = ST_DONE;
                     end
                  end else begin
                     frame_d = frame_q + 8'd1;
                  end
               end
            end
            ST_PAUSE: begin
               if (!i_pause) state_d = ST_RUN;
            end
            default: ;
         endcase
      end

      valid_d = changed | (valid_q & ~i_ready);
      busy_d  = (state_d == ST_RUN) || (state_d == ST_PAUSE);
      done_d  = (state_d == ST_DONE);
`ifdef DIST_WARN_EN
      warn_d  = (digits_d < bcd3_t'(WARN_BCD)) && (state_d != ST_IDLE);
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         sync3_q  <= 1'b0;
         state_q  <= ST_IDLE;
         digits_q <= bcd3_t'(START_BCD);
         frame_q  <= '0;
         valid_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef DIST_WARN_EN
         warn_q   <= 1'b0;
`endif
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         sync3_q  <= sync3_d;
         state_q  <= state_d;
         digits_q <= digits_d;
         frame_q  <= frame_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef DIST_WARN_EN
         warn_q   <= warn_d;
`endif
      end
   end

   assign o_hundreds = digits_q.hundreds;
   assign o_tens     = digits_q.tens;
   assign o_units    = digits_q.units;
   assign o_valid    = valid_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
`ifdef DIST_WARN_EN
   assign o_warn     = warn_q;
`endif

endmodule

// File: tb/tb_distance_counter.sv
// Self-checking bench for distance_counter: integer-valued reference model plus directed scenarios.
module tb_distance_counter;

   localparam int DIV   = 80;
   localparam int START = 200;
   localparam int WARN  = 50;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v_sync = 1'b0;
   logic        start = 1'b0;
   logic        load = 1'b0;
   logic [11:0] load_bcd = '0;
   logic        pause = 1'b0;
   logic        ready = 1'b0;
   logic [3:0]  hundreds, tens, units;
   logic        valid, busy, done;
`ifdef DIST_WARN_EN
   logic        warn;
`endif

   always #5 clk = ~clk;

   distance_counter dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_v_sync   (v_sync),
      .i_start    (start),
      .i_load     (load),
      .i_load_bcd (load_bcd),
      .i_pause    (pause),
      .i_ready    (ready),
      .o_hundreds (hundreds),
      .o_tens     (tens),
      .o_units    (units),
      .o_valid    (valid),
      .o_busy     (busy),
      .o_done     (done)
`ifdef DIST_WARN_EN
      ,.o_warn    (warn)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: distance as a plain integer, mode 0=idle 1=run 2=pause 3=done.
   int m_val    = START;
   int m_frames = 0;
   int m_mode   = 0;
   bit m_valid  = 1'b1;
   bit sp1 = 1'b0, sp2 = 1'b0, sp3 = 1'b0;   // v_sync seen at the last three edges
   bit rand_ready = 1'b0;
   bit rand_pause = 1'b0;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 9 : int'(d);
   endfunction

   function automatic logic [11:0] dig();
      return {hundreds, tens, units};
   endfunction

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      bit tick;
      bit changed;
      int v;
      tick    = sp2 && !sp3;
      changed = 1'b0;
      if (rst) begin
         m_mode = 0; m_val = START; m_frames = 0; m_valid = 1'b1;
         sp1 = 1'b0; sp2 = 1'b0; sp3 = 1'b0;
      end else begin
         if (start) begin
            v = load ? clamp9(load_bcd[11:8]) * 100 + clamp9(load_bcd[7:4]) * 10 + clamp9(load_bcd[3:0])
                     : START;
            m_val = v; m_frames = 0; changed = 1'b1;
            m_mode = (v == 0) ? 3 : 1;
         end else if (m_mode == 1) begin
            if (pause) m_mode = 2;
            else if (tick) begin
               m_frames++;
               if (m_frames == DIV) begin
                  m_frames = 0; m_val--; changed = 1'b1;
                  if (m_val == 0) m_mode = 3;
               end
            end
         end else if (m_mode == 2 && !pause) begin
            m_mode = 1;
         end
         if (changed) m_valid = 1'b1;
         else if (m_valid && ready) m_valid = 1'b0;
         sp3 = sp2; sp2 = sp1; sp1 = v_sync;
      end
      @(posedge clk);
      #1;
      check("cyc_digits", dig(), to_bcd(m_val));
      check("cyc_valid", 12'(valid), 12'(m_valid));
      check("cyc_busy", 12'(busy), 12'(m_mode == 1 || m_mode == 2));
      check("cyc_done", 12'(done), 12'(m_mode == 3));
`ifdef DIST_WARN_EN
      check("cyc_warn", 12'(warn), 12'(m_val < WARN && m_mode != 0));
`endif
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         if (rand_ready) ready = 1'($urandom);
         if (rand_pause) pause = ($urandom_range(0, 3) == 0);
         v_sync = 1'b1;
         repeat ($urandom_range(1, 3)) cycle();
         v_sync = 1'b0;
         repeat ($urandom_range(2, 4)) cycle();
      end
   endtask

   task automatic do_start(input bit ld, input logic [11:0] bcd);
      load = ld; load_bcd = bcd; start = 1'b1;
      cycle();
      start = 1'b0; load = 1'b0;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      cycle(); cycle();
      check("rst_digits", dig(), 12'h200);
      check("rst_valid", 12'(valid), 12'h1);
      check("rst_busy", 12'(busy), 12'h0);
      check("rst_done", 12'(done), 12'h0);
      rst = 1'b0;
      ready = 1'b1;
      cycle();
      check("idle_valid_clr", 12'(valid), 12'h0);

      // Default load, first decrement latency after the 80th v_sync rise
      do_start(1'b0, 12'h000);
      check("start_busy", 12'(busy), 12'h1);
      frames(DIV - 1);
      check("pre80_digits", dig(), 12'h200);
      check("pre80_valid", 12'(valid), 12'h0);
      v_sync = 1'b1; cycle();
      v_sync = 1'b0; cycle();
      check("lat2_digits", dig(), 12'h200);
      cycle();
      check("lat3_digits", dig(), 12'h199);
      check("lat3_valid", 12'(valid), 12'h1);
      cycle();

      // Count down to zero and stay there
      do_start(1'b1, 12'h001);
      frames(DIV);
      check("zero_digits", dig(), 12'h000);
      check("zero_done", 12'(done), 12'h1);
      check("zero_busy", 12'(busy), 12'h0);
      frames(200);
      check("zero_hold", dig(), 12'h000);

      // Loading 000 goes straight to DONE
      do_start(1'b1, 12'h000);
      check("load0_done", 12'(done), 12'h1);
      check("load0_busy", 12'(busy), 12'h0);

      // Clamp, pause hold, resume
      do_start(1'b1, 12'h10A);
      check("clamp_digits", dig(), 12'h109);
      pause = 1'b1;
      frames(300);
      check("pause_digits", dig(), 12'h109);
      check("pause_busy", 12'(busy), 12'h1);
      pause = 1'b0;
      cycle();
      frames(DIV);
      check("resume_digits", dig(), 12'h108);

      // Borrow across two digits
      do_start(1'b1, 12'h100);
      frames(DIV);
      check("borrow_digits", dig(), 12'h099);

      // Start and pause together: start wins, pause follows
      pause = 1'b1;
      do_start(1'b0, 12'h000);
      frames(5);
      check("startpause_digits", dig(), 12'h200);
      check("startpause_busy", 12'(busy), 12'h1);
      pause = 1'b0;
      cycle();

      // Renderer stalled for three decrements
      ready = 1'b0;
      do_start(1'b0, 12'h000);
      frames(3 * DIV);
      check("stall_digits", dig(), 12'h197);
      check("stall_valid", 12'(valid), 12'h1);
      ready = 1'b1;
      cycle();
      check("accept_valid", 12'(valid), 12'h0);
      check("accept_digits", dig(), 12'h197);

      // Reset mid-count
      do_start(1'b1, 12'h150);
      frames(40);
      rst = 1'b1; start = 1'b1; v_sync = 1'b1;
      cycle();
      rst = 1'b0; start = 1'b0; v_sync = 1'b0;
      check("midrst_digits", dig(), 12'h200);
      check("midrst_busy", 12'(busy), 12'h0);
      check("midrst_valid", 12'(valid), 12'h1);
      frames(100);
      check("midrst_hold", dig(), 12'h200);
      check("midrst_idle", 12'(busy), 12'h0);

      // Randomised loads, ready and pause against the model
      rand_ready = 1'b1;
      rand_pause = 1'b1;
      for (int k = 0; k < 6; k++) begin
         do_start(1'($urandom), 12'($urandom));
         frames($urandom_range(20, 120));
      end
      rand_ready = 1'b0;
      rand_pause = 1'b0;
      pause = 1'b0;
      ready = 1'b1;
      cycle();

`ifdef DIST_WARN_EN
      do_start(1'b1, 12'h051);
      check("warn_051", 12'(warn), 12'h0);
      frames(DIV);
      check("warn_050_digits", dig(), 12'h050);
      check("warn_050", 12'(warn), 12'h0);
      frames(DIV);
      check("warn_049_digits", dig(), 12'h049);
      check("warn_049", 12'(warn), 12'h1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/distance_counter.md
DISTANCE_COUNTER -- requirements
Module: distance_counter

Interface
REQ-001 Parameter FRAME_DIV, default 80: number of frame ticks per one-unit decrement (legal range 1..255).
REQ-002 Parameter START_BCD, default 12'h200: value loaded on reset and on i_start when i_load is low.
REQ-003 Parameter WARN_BCD, default 12'h050: warning threshold, used only when DIST_WARN_EN is defined.
REQ-004 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_v_sync  in  1  VGA vertical sync level, asynchronous to i_clk.
REQ-007 i_start  in  1  one-cycle pulse; loads a value and starts counting.
REQ-008 i_load  in  1  with i_start: high loads i_load_bcd, low loads START_BCD.
REQ-009 i_load_bcd  in  12  packed BCD {hundreds, tens, units}.
REQ-010 i_pause  in  1  level; while high the frame counter and digits hold.
REQ-011 i_ready  in  1  the renderer accepts the current digit set.
REQ-012 o_hundreds, o_tens, o_units  out  4 each  current BCD digits.
REQ-013 o_valid  out  1  the digit set has changed since the last accept.
REQ-014 o_busy  out  1  high in RUN or PAUSE.
REQ-015 o_done  out  1  high in DONE (count reached 000).
REQ-016 o_warn  out  1  present only with DIST_WARN_EN.

Function
REQ-017 i_v_sync passes through a 2-flop synchroniser followed by a rising-edge detector; the frame tick asserts for one cycle, 3 i_clk cycles after i_v_sync rises.
REQ-018 FSM states: IDLE, RUN, PAUSE, DONE; after reset the FSM is in IDLE.
REQ-019 From any state, i_start loads the digits, clears the frame counter, and enters RUN; if the loaded value is 000, it enters DONE instead.
REQ-020 Loaded digits above 9 are clamped to 9 per digit.
REQ-021 RUN to PAUSE when i_pause is high; PAUSE to RUN when i_pause is low; PAUSE holds the frame counter.
REQ-022 i_start and i_pause in the same cycle: i_start wins; the next state is RUN, and PAUSE is entered on the following cycle if i_pause is still high.
REQ-023 In RUN, each frame tick increments the 8-bit frame counter; on the tick where the counter equals FRAME_DIV-1, the counter returns to 0 and the value decrements by exactly 1 on that edge.
REQ-024 Decrement is BCD: a units borrow 0 to 9 decrements tens, and a tens borrow 0 to 9 decrements hundreds. Example: 100 becomes 099.
REQ-025 When the result of a decrement is 000, the FSM enters DONE on the same edge; in DONE the digits hold at 000 and ticks are ignored.
REQ-026 o_valid is set on every edge that changes the digits (load or decrement) and is cleared on an edge where o_valid and i_ready are both high.
REQ-027 If a change and an accept occur in the same cycle, o_valid stays high.
REQ-028 Accepting does not stall counting: latest-value semantics apply, and unaccepted intermediate values are overwritten.
REQ-029 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-030 On i_rst: FSM to IDLE, digits to START_BCD, frame counter 0, o_valid 1, o_busy 0, o_done 0, o_warn 0, synchroniser flops 0.
REQ-031 Reset mid-count overrides every other input in that cycle.

Configuration
REQ-032 Macro DIST_WARN_EN.
  - Defined: o_warn is registered and high whenever the digits are below WARN_BCD (BCD compare) and the FSM is not IDLE.
  - Not defined: the o_warn port and its logic are absent.

Structure
REQ-033 Package distance_pkg holds:
  - the bcd3_t typedef (3 x 4-bit digits)
  - the FSM state enum
  - the FRAME_DIV default
  - the START_BCD default
  - the WARN_BCD default
REQ-034 Sub-module bcd_digit_dec: a single-digit decrement with borrow-in and borrow-out, instantiated 3 times in a chain.

Verification
REQ-035 Reset, then i_start with i_load=0 and 80 v_sync pulses: digits go from 200 to 199 three cycles after the 80th rising edge; o_valid rises on that edge.
REQ-036 Load 001 and run 80 frames: digits reach 000, o_done=1, o_busy=0; a further 200 frames leave the digits at 000.
REQ-037 Load 10A: digits load as 109; i_pause high for 300 frames gives no change; after release, 80 frames give 108.
REQ-038 i_ready held low for 3 decrements from 200: the digits read 197 with o_valid=1; one i_ready cycle clears o_valid.
REQ-039 Pulse i_rst 40 frames into a count: digits return to 200, FSM to IDLE, and subsequent ticks give no decrement.
REQ-040 With DIST_WARN_EN and a load of 051: o_warn=0; after 80 frames (value 050) o_warn=0; after 160 frames (value 049) o_warn=1.
